// File: rtl/chunk_accumulator_57_pkg.sv
// ============================================================================
// Module : chunk_accumulator_57_pkg
// Desc   : Shared widths, state encoding and saturation constant for the
//          chunk accumulator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chunk_accumulator_57_pkg;

  localparam int ACC_W   = 57;
  localparam int CHUNK_W = 19;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] c_acc_ones = '1;

endpackage

`default_nettype wire

// File: rtl/chunk_accumulator_57_adder.sv
// ============================================================================
// Module : chunk_accumulator_57_adder
// Desc   : Zero-extending adder stage: ACC_W-bit operand plus CHUNK_W-bit
//          operand, producing an ACC_W+1-bit sum with carry in the MSB.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_accumulator_57_adder #(
  parameter int ACC_W   = 57,
  parameter int CHUNK_W = 19
) (
  input  logic [ACC_W-1:0]   A,
  input  logic [CHUNK_W-1:0] B,
  output logic [ACC_W:0]     Sum
);

  assign Sum = {1'b0, A} + {{(ACC_W - CHUNK_W + 1){1'b0}}, B};

endmodule

`default_nettype wire

// File: rtl/chunk_accumulator_57.sv
// ============================================================================
// Module : chunk_accumulator_57
// Desc   : Accumulates a valid/ready stream of chunks per packet and holds the
//          total, sticky overflow and chunk count until accepted.
//          Build option CHUNK_ACC_SATURATE_EN: clamp at all-ones on carry-out
//          instead of wrapping modulo 2^ACC_W.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_accumulator_57
  import chunk_accumulator_57_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_chunk,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_ovf,
  output logic [CNT_W-1:0]   out_count
);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_count;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_sum;
  logic               r_out_ovf;
  logic [CNT_W-1:0]   r_out_count;

  logic [ACC_W:0]     w_sum;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_ovf_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_accept;

  chunk_accumulator_57_adder #(
    .ACC_W   (ACC_W),
    .CHUNK_W (CHUNK_W)
  ) u_adder (
    .A   (r_acc),
    .B   (in_chunk),
    .Sum (w_sum)
  );

  // acc/ovf/count are zero whenever IDLE, so the same update covers the first chunk
  assign w_carry    = w_sum[ACC_W];
`ifdef CHUNK_ACC_SATURATE_EN
  assign w_acc_next = w_carry ? c_acc_ones : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif
  assign w_ovf_next = r_ovf | w_carry;
  assign w_cnt_next = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);
  assign w_accept   = in_valid && r_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_acc_next;
            r_ovf   <= w_ovf_next;
            r_count <= w_cnt_next;
            if (in_last) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_sum   <= w_acc_next;
              r_out_ovf   <= w_ovf_next;
              r_out_count <= w_cnt_next;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign out_count = r_out_count;

endmodule

`default_nettype wire

// File: tb/tb_chunk_accumulator_57.sv
// ============================================================================
// Module : tb_chunk_accumulator_57
// Desc   : Scoreboard bench for chunk_accumulator_57 (honours
//          CHUNK_ACC_SATURATE_EN when compiled with it).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chunk_accumulator_57;

  typedef struct {
    logic [56:0] sum;
    logic        ovf;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [18:0] in_chunk = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [56:0] out_sum;
  logic        out_ovf;
  logic [7:0]  out_count;

  int   vectors = 0;
  int   miscompares = 0;
  int   sink_hold = 0;
  exp_t exp_q[$];
  int   chunk_q[$];

  chunk_accumulator_57 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chunk  (in_chunk),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: plain running sum with overflow detected against 2^57
  function automatic void push_expect();
    logic [63:0] total = 0;
    logic        ovf = 1'b0;
    int          cnt = 0;
    exp_t        e;
    foreach (chunk_q[i]) begin
      total += 64'(chunk_q[i]);
      if (total >= 64'h0200_0000_0000_0000) begin
        ovf = 1'b1;
`ifdef CHUNK_ACC_SATURATE_EN
        total = 64'h01FF_FFFF_FFFF_FFFF;
`else
        total -= 64'h0200_0000_0000_0000;
`endif
      end
      cnt++;
    end
    e.sum = total[56:0];
    e.ovf = ovf;
    e.cnt = (cnt > 255) ? 8'd255 : 8'(cnt);
    exp_q.push_back(e);
  endfunction

  // Monitor / sink: pops on each new result, checks stability while held
  initial begin : monitor
    logic        seen = 1'b0;
    int          held = 0;
    logic [56:0] s_sum;
    logic        s_ovf;
    logic [7:0]  s_cnt;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        out_ready = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_sum", 64'(out_sum), 64'(e.sum));
            chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
            chk("out_count", 64'(out_count), 64'(e.cnt));
          end
          s_sum = out_sum;
          s_ovf = out_ovf;
          s_cnt = out_count;
          seen  = 1'b1;
          held  = 0;
        end else begin
          chk("hold_sum_stable", 64'(out_sum), 64'(s_sum));
          chk("hold_ovf_stable", 64'(out_ovf), 64'(s_ovf));
          chk("hold_cnt_stable", 64'(out_count), 64'(s_cnt));
        end
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        out_ready = (held >= sink_hold);
        held++;
      end else begin
        if (seen) chk("in_ready_after_accept", 64'(in_ready), 64'd1);
        seen = 1'b0;
        out_ready = 1'($urandom_range(1));
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        in_valid = 1'b0;
        break;
      end
      // Garbage offered during HOLD must be ignored
      in_valid = 1'($urandom_range(1));
      in_chunk = 19'($urandom);
      in_last  = 1'($urandom_range(1));
      if (++guard > 2000) begin
        chk("wait_in_ready_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
  endtask

  task automatic send_packet(input int gap_pct);
    int i = 0;
    int guard = 0;
    int n = chunk_q.size();
    push_expect();
    wait_ready();
    while (i < n) begin
      if (i > 0) @(negedge clk);
      if (in_ready && ($urandom_range(99) >= gap_pct)) begin
        in_valid = 1'b1;
        in_chunk = 19'(chunk_q[i]);
        in_last  = (i == n - 1);
        i++;
      end else begin
        in_valid = 1'b0;
        in_chunk = 19'($urandom);
        in_last  = 1'($urandom_range(1));
      end
      if (++guard > 20000) begin
        chk("send_timeout", 64'(i), 64'(n));
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    chk("latency_in_ready", 64'(in_ready), 64'd0);
  endtask

  initial begin : stimulus
    int guard;
    exp_t e;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    rst = 1'b0;

    // Single max chunk
    sink_hold = 2;
    chunk_q = '{32'h7FFFF};
    send_packet(0);

    // Back-to-back small packet, consumer stalls
    sink_hold = 4;
    chunk_q = '{5, 10, 20};
    send_packet(0);

    // Near-full accumulator plus one: wrap or clamp
    sink_hold = 1;
    wait_ready();
    e.sum = 57'h0;
    e.ovf = 1'b1;
    e.cnt = 8'd2;
`ifdef CHUNK_ACC_SATURATE_EN
    e.sum = 57'h1FF_FFFF_FFFF_FFFF;
`endif
    exp_q.push_back(e);
    in_valid = 1'b1; in_chunk = 19'h7FFFF; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    force dut.r_acc = 57'h1FF_FFFF_FFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b1; in_chunk = 19'd1; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    release dut.r_acc;
    chk("ovf_latency_valid", 64'(out_valid), 64'd1);

    // Count saturation
    sink_hold = 0;
    chunk_q.delete();
    for (int k = 0; k < 300; k++) chunk_q.push_back(1);
    send_packet(0);

    // Reset in the middle of a packet
    wait_ready();
    in_valid = 1'b1; in_chunk = 19'd11; in_last = 1'b0;
    @(negedge clk);
    in_chunk = 19'd22;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_sum", 64'(out_sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chunk_q = '{7};
    send_packet(0);

    // Bubbles must not double-count
    sink_hold = 1;
    chunk_q = '{100, 200, 300};
    send_packet(60);

    // Randomized packets
    for (int p = 0; p < 25; p++) begin
      int len = $urandom_range(1, 6);
      sink_hold = $urandom_range(0, 3);
      chunk_q.delete();
      for (int k = 0; k < len; k++) chunk_q.push_back(int'($urandom_range(0, 19'h7FFFF)));
      send_packet($urandom_range(0, 50));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
